blram_boot_ctrl: RTL and testbench
==================================

Name: blram_boot_ctrl

Overview:
- Owns the single port of the blram and shares it between the VerySimpleCPU and a host-side loader/dumper.
- Holds the CPU in reset while the host streams a program image into RAM.
- Releases the CPU to run, halts it on request, and streams a RAM region back to the host.
- Sits between VerySimpleCPU/blram and the host interface in the top level.

Parameters:
- SIZE, 14, RAM address width (matches blram SIZE)
- DEPTH, 1024, RAM words; all address counters wrap modulo DEPTH
- AUTO_RUN, 0, 1 = enter RUN automatically after the last load beat

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse: begin load at ld_base (accepted in IDLE only)
- ld_base  in  SIZE  load start address, sampled with load_start
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted
- ld_data  in  32  load word
- ld_last  in  1  final load beat
- run_start  in  1  pulse: release CPU (IDLE only)
- halt_req  in  1  pulse: stop CPU (RUN only)
- dump_start  in  1  pulse: begin dump (IDLE only)
- dump_base  in  SIZE  dump start address, sampled with dump_start
- dump_len  in  SIZE+1  dump word count, sampled with dump_start
- dump_valid  out  1  dump word valid
- dump_ready  in  1  host accepts dump word
- dump_data  out  32  dump word
- dump_last  out  1  final dump word
- cpu_rst  out  1  reset to VerySimpleCPU
- cpu_wrEn  in  1  CPU write enable
- cpu_addr  in  SIZE  CPU address
- cpu_data_toRAM  in  32  CPU write data
- cpu_data_fromRAM  out  32  RAM read data to CPU (wired to ram_data_out)
- ram_we  out  1  blram i_we
- ram_addr  out  SIZE  blram i_addr
- ram_data_in  out  32  blram i_ram_data_in
- ram_data_out  in  32  blram o_ram_data_out (1-cycle read latency)
- state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 DUMP
- load_count  out  SIZE+1  words written by the last load

Behaviour:
- Reset (async): state=IDLE, cpu_rst=1, ld_ready=0, dump_valid=0, dump_last=0, dump_data=0, load_count=0, counters=0.
- RAM port mux is combinational on the registered state.
  - RUN: cpu_* passes through to ram_*.
  - LOAD: ram_we=ld_valid, ram_addr=load ptr, ram_data_in=ld_data.
  - DUMP: ram_we=0, ram_addr=read ptr.
  - IDLE: ram_we=0, ram_addr=0, ram_data_in=0.
- IDLE transitions:
  - load_start -> LOAD; ptr=ld_base; load_count cleared to 0.
  - dump_start -> DUMP.
  - run_start -> RUN.
  - Simultaneous pulses: load > dump > run.
- Start pulses outside IDLE are ignored. halt_req outside RUN is ignored.
- LOAD:
  - ld_ready=1 combinationally. Each ld_valid beat writes RAM in that cycle, ptr=(ptr+1) mod DEPTH, load_count+1.
  - A beat with ld_last returns to IDLE, or to RUN if AUTO_RUN=1.
  - The load_count register saturates at DEPTH; the write pointer keeps wrapping.
- cpu_rst is registered. It goes 0 on the edge that enters RUN and goes 1 on the edge that leaves RUN. It is 1 in every other state.
- RUN:
  - halt_req in cycle N: the CPU still owns the port in cycle N, so a write in that cycle completes.
  - At edge N+1: state=IDLE, cpu_rst=1.
- DUMP:
  - dump_len=0: return to IDLE next cycle, no beats.
  - Otherwise issue a read at ptr when in-flight + buffered < 2, then ptr=(ptr+1) mod DEPTH. Data arrives one cycle later into a 2-entry skid buffer.
  - dump_valid/dump_data/dump_last are driven from the buffer head. dump_data holds stable while dump_valid && !dump_ready.
  - With dump_ready held high, words stream back-to-back after 2 cycles of initial latency.
  - After the last word is accepted: state=IDLE, dump_valid=0 on that edge.
- Async reset mid-operation aborts immediately:
  - A partial load stays in RAM.
  - Dump data in flight is discarded.
  - cpu_rst returns to 1.

Decomposition:
- Package blram_boot_pkg holds:
  - the state encoding (IDLE/LOAD/RUN/DUMP, 2 bits)
  - the 32-bit data-width constant
- Sub-module blram_rd_skid: 2-entry valid/ready buffer with in-flight credit tracking for the DUMP read path.

Test Plan:
- Basic load then run:
  - Stimulus: load_start, ld_base=0, 3 beats 0x20114045, 0x10114001, 0xb0118064 (last on 3rd); then run_start.
  - Response: RAM[0..2] hold those words; load_count=3; cpu_rst falls exactly 1 edge after run_start; ram_addr follows cpu_addr.
- Load wrap and AUTO_RUN:
  - Stimulus: ld_base=1022, 4 beats, AUTO_RUN=1.
  - Response: writes land at 1022, 1023, 0, 1; state goes LOAD->RUN after the last beat with no run_start.
- Dump with backpressure:
  - Stimulus: RAM[69]=1, RAM[70]=0x3e8; dump_base=69, dump_len=2; dump_ready toggles 1,0,0,1.
  - Response: exactly 2 beats, 0x1 then 0x3e8 with dump_last=1; data stable while stalled; then IDLE.
- Halt with write in the same cycle:
  - Stimulus: halt_req in the same cycle as cpu_wrEn=1 to addr 101, data 7.
  - Response: RAM[101]=7; next edge state=IDLE, cpu_rst=1.
- Edge-case commands:
  - dump_len=0 -> zero dump_valid beats, IDLE after 1 cycle.
  - load_start, dump_start and run_start together -> LOAD.
  - run_start during LOAD -> ignored.
- Reset mid-dump:
  - Stimulus: rst asserted during DUMP with dump_valid=1.
  - Response: dump_valid=0, state=IDLE, cpu_rst=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/blram_boot_pkg.sv
// Shared definitions for the blram boot controller: controller state encoding
// and the RAM word width.
package blram_boot_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } boot_state_t;

endpackage

// File: rtl/blram_rd_skid.sv
// Two-entry valid/ready buffer for the DUMP read path. It tracks the single
// read in flight through the 1-cycle RAM so that at most two words are ever owed.
module blram_rd_skid
  import blram_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ready,
  output logic              can_issue,
  output logic              head_valid,
  output logic              head_last,
  output logic [DATA_W-1:0] head_data,
  output logic              empty
);

  logic              vld_p0;
  logic              last_p0;
  logic [1:0]        count;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              last0;
  logic              last1;
  logic              push;
  logic              pop;
  logic [1:0]        occ;

  assign push       = vld_p0;
  assign head_valid = (count != 2'd0);
  assign pop        = head_valid && ready;
  assign head_data  = data0;
  assign head_last  = last0;
  assign empty      = !vld_p0 && (count == 2'd0);

  // A word popped this cycle frees its slot in time for a new read.
  assign occ       = count + {1'b0, vld_p0} - {1'b0, pop};
  assign can_issue = (occ < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      count   <= 2'd0;
      data0   <= '0;
      data1   <= '0;
      last0   <= 1'b0;
      last1   <= 1'b0;
    end else begin
      // stage p0: read issued last cycle, RAM data valid now
      vld_p0  <= issue;
      last_p0 <= issue && issue_last;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= rd_data;
            last0 <= last_p0;
          end else begin
            data1 <= rd_data;
            last1 <= last_p0;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= rd_data;
            last0 <= last_p0;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= rd_data;
            last1 <= last_p0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/blram_boot_ctrl.sv
// Owns the blram port and arbitrates it between the CPU and a host loader/dumper;
// holds the CPU in reset except while in RUN.
module blram_boot_ctrl
  import blram_boot_pkg::*;
#(
  parameter int SIZE     = 14,
  parameter int DEPTH    = 1024,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [SIZE-1:0]   ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              run_start,
  input  logic              halt_req,
  input  logic              dump_start,
  input  logic [SIZE-1:0]   dump_base,
  input  logic [SIZE:0]     dump_len,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              cpu_rst,
  input  logic              cpu_wrEn,
  input  logic [SIZE-1:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_toRAM,
  output logic [DATA_W-1:0] cpu_data_fromRAM,
  output logic              ram_we,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [1:0]        state,
  output logic [SIZE:0]     load_count
);

  localparam int            LAST_IDX  = DEPTH - 1;
  localparam logic [SIZE-1:0] LAST_ADDR = LAST_IDX[SIZE-1:0];
  localparam logic [SIZE:0]   CNT_MAX   = DEPTH[SIZE:0];

  function automatic logic [SIZE-1:0] wrap_inc(input logic [SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + SIZE'(1);
  endfunction

  function automatic logic [SIZE:0] sat_inc(input logic [SIZE:0] c);
    return (c == CNT_MAX) ? c : c + (SIZE+1)'(1);
  endfunction

  boot_state_t     st;
  logic [SIZE-1:0] ptr;
  logic [SIZE:0]   rd_left;
  logic            issue;
  logic            can_issue;
  logic            head_valid;
  logic            head_last;
  logic            skid_empty;

  assign state            = st;
  assign ld_ready         = (st == ST_LOAD);
  assign cpu_data_fromRAM = ram_data_out;
  assign issue            = (st == ST_DUMP) && (rd_left != '0) && can_issue;
  assign dump_valid       = head_valid;
  assign dump_last        = head_valid && head_last;

  blram_rd_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_last (rd_left == (SIZE+1)'(1)),
    .rd_data    (ram_data_out),
    .ready      (dump_ready),
    .can_issue  (can_issue),
    .head_valid (head_valid),
    .head_last  (head_last),
    .head_data  (dump_data),
    .empty      (skid_empty)
  );

  // Port mux keys off the registered state, so a halt cycle still belongs to the CPU.
  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    case (st)
      ST_RUN: begin
        ram_we      = cpu_wrEn;
        ram_addr    = cpu_addr;
        ram_data_in = cpu_data_toRAM;
      end
      ST_LOAD: begin
        ram_we      = ld_valid;
        ram_addr    = ptr;
        ram_data_in = ld_data;
      end
      ST_DUMP: ram_addr = ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      cpu_rst    <= 1'b1;
      ptr        <= '0;
      rd_left    <= '0;
      load_count <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (load_start) begin
            st         <= ST_LOAD;
            ptr        <= ld_base;
            load_count <= '0;
          end else if (dump_start) begin
            st      <= ST_DUMP;
            ptr     <= dump_base;
            rd_left <= dump_len;
          end else if (run_start) begin
            st      <= ST_RUN;
            cpu_rst <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ptr        <= wrap_inc(ptr);
            load_count <= sat_inc(load_count);
            if (ld_last) begin
              if (AUTO_RUN) begin
                st      <= ST_RUN;
                cpu_rst <= 1'b0;
              end else begin
                st <= ST_IDLE;
              end
            end
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            st      <= ST_IDLE;
            cpu_rst <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (issue) begin
            ptr     <= wrap_inc(ptr);
            rd_left <= rd_left - (SIZE+1)'(1);
          end
          // Second term covers a zero-length request, which never produces a beat.
          if ((dump_ready && head_valid && head_last) ||
              ((rd_left == '0) && skid_empty))
            st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blram_boot_ctrl.sv
// Bench for blram_boot_ctrl: two instances (AUTO_RUN 0 and 1) share stimulus,
// each with its own blram model; results are compared against a reference memory.
module tb_blram_boot_ctrl;
  localparam int SIZE  = 14;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic load_start, ld_valid, ld_last, run_start, halt_req, dump_start, dump_ready, cpu_wrEn;
  logic [SIZE-1:0] ld_base, dump_base, cpu_addr;
  logic [SIZE:0]   dump_len;
  logic [31:0]     ld_data, cpu_data_toRAM;

  logic            ld_ready, dump_valid, dump_last, cpu_rst, ram_we;
  logic [31:0]     dump_data, cpu_data_fromRAM, ram_data_in, ram_data_out;
  logic [SIZE-1:0] ram_addr;
  logic [1:0]      state;
  logic [SIZE:0]   load_count;

  logic            ld_ready2, dump_valid2, dump_last2, cpu_rst2, ram_we2;
  logic [31:0]     dump_data2, cpu_data_fromRAM2, ram_data_in2, ram_data_out2;
  logic [SIZE-1:0] ram_addr2;
  logic [1:0]      state2;
  logic [SIZE:0]   load_count2;

  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem2 [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] words [1100];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr % DEPTH] <= ram_data_in;
    ram_data_out <= mem1[ram_addr % DEPTH];
    if (ram_we2) mem2[ram_addr2 % DEPTH] <= ram_data_in2;
    ram_data_out2 <= mem2[ram_addr2 % DEPTH];
  end

  blram_boot_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .run_start(run_start), .halt_req(halt_req), .dump_start(dump_start),
    .dump_base(dump_base), .dump_len(dump_len), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
    .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
    .cpu_data_toRAM(cpu_data_toRAM), .cpu_data_fromRAM(cpu_data_fromRAM),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .state(state), .load_count(load_count));

  blram_boot_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .AUTO_RUN(1'b1)) dut_auto (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_data(ld_data), .ld_last(ld_last),
    .run_start(run_start), .halt_req(halt_req), .dump_start(dump_start),
    .dump_base(dump_base), .dump_len(dump_len), .dump_valid(dump_valid2),
    .dump_ready(dump_ready), .dump_data(dump_data2), .dump_last(dump_last2),
    .cpu_rst(cpu_rst2), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
    .cpu_data_toRAM(cpu_data_toRAM), .cpu_data_fromRAM(cpu_data_fromRAM2),
    .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_data_in(ram_data_in2),
    .ram_data_out(ram_data_out2), .state(state2), .load_count(load_count2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams words[0..n-1] starting at base; gaps inserts random idle cycles.
  task automatic do_load(input int base, input int n, input bit gaps);
    int k;
    int budget;
    logic v;
    ld_base = SIZE'(base);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_enter", 64'(state), 64'd1);
    chk("load_ready", 64'(ld_ready), 64'd1);
    chk("load_cnt_clr", 64'(load_count), 64'd0);
    k = 0;
    budget = 0;
    while (k < n && budget < 4 * n + 20) begin
      v = gaps ? ($urandom_range(3) != 0) : 1'b1;
      ld_valid = v;
      ld_data  = words[k];
      ld_last  = v && (k == n - 1);
      #1;
      chk("load_we", 64'(ram_we), 64'(v));
      if (v) chk("load_addr", 64'(ram_addr), 64'((base + k) % DEPTH));
      step();
      if (v) begin
        ref_mem[(base + k) % DEPTH] = words[k];
        k++;
      end
      budget++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_beats", 64'(k), 64'(n));
    chk("load_exit", 64'(state), 64'd0);
    chk("autorun_state", 64'(state2), 64'd2);
    chk("autorun_cpu_rst", 64'(cpu_rst2), 64'd0);
    chk("load_count", 64'(load_count), 64'((n > DEPTH) ? DEPTH : n));
    for (int i = 0; i < n && i < 8; i++)
      chk("load_mem", 64'(mem1[(base + i) % DEPTH]), 64'(ref_mem[(base + i) % DEPTH]));
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_ignored_idle", 64'(state), 64'd0);
    chk("halt_autorun", 64'(state2), 64'd0);
  endtask

  // mode 0: random ready, 1: ready pattern 1,0,0,1 on valid cycles, 2: ready held high
  task automatic do_dump(input int base, input int len, input int mode);
    int k;
    int cyc;
    int first_v;
    int pat_i;
    int done_cyc;
    logic [31:0] held;
    logic stalled;
    logic r;
    logic [3:0] pat;
    pat = 4'b1001;
    dump_base = SIZE'(base);
    dump_len = (SIZE+1)'(len);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("dump_enter", 64'(state), 64'd3);
    k = 0; cyc = 0; first_v = -1; pat_i = 0; stalled = 1'b0; done_cyc = -1; held = '0;
    while (cyc < 8 * len + 20) begin
      if (state != 2'd3) begin
        done_cyc = cyc;
        break;
      end
      if (stalled) begin
        chk("dump_hold_valid", 64'(dump_valid), 64'd1);
        chk("dump_hold_data", 64'(dump_data), 64'(held));
      end
      if (dump_valid && first_v < 0) first_v = cyc;
      case (mode)
        0: r = 1'($urandom_range(1));
        1: r = pat[pat_i % 4];
        default: r = 1'b1;
      endcase
      if (dump_valid && mode == 1) pat_i++;
      dump_ready = r;
      if (dump_valid && r) begin
        chk("dump_data", 64'(dump_data), 64'(ref_mem[(base + k) % DEPTH]));
        chk("dump_last", 64'(dump_last), 64'(k == len - 1));
        k++;
      end
      stalled = dump_valid && !r;
      held = dump_data;
      step();
      cyc++;
    end
    dump_ready = 1'b0;
    chk("dump_beats", 64'(k), 64'(len));
    chk("dump_exit", 64'(state), 64'd0);
    chk("dump_valid_after", 64'(dump_valid), 64'd0);
    if (len == 0) chk("dump_zero_cycles", 64'(done_cyc), 64'd1);
    if (mode == 2 && len > 0) begin
      chk("dump_first_latency", 64'(first_v), 64'd2);
      chk("dump_stream_cycles", 64'(done_cyc), 64'(len + 2));
    end
  endtask

  initial begin
    logic [31:0] w;
    int b;
    rst = 1'b1;
    load_start = 0; ld_valid = 0; ld_last = 0; run_start = 0; halt_req = 0;
    dump_start = 0; dump_ready = 0; cpu_wrEn = 0;
    ld_base = '0; dump_base = '0; cpu_addr = '0; dump_len = '0;
    ld_data = '0; cpu_data_toRAM = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_last", 64'(dump_last), 64'd0);
    chk("rst_dump_data", 64'(dump_data), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    rst = 1'b0;
    step();

    // basic load then run, CPU traffic, halt with a same-cycle write
    words[0] = 32'h20114045; words[1] = 32'h10114001; words[2] = 32'hb0118064;
    do_load(0, 3, 1'b0);
    run_start = 1'b1;
    #1;
    chk("cpu_rst_before_edge", 64'(cpu_rst), 64'd1);
    step();
    run_start = 1'b0;
    chk("run_state", 64'(state), 64'd2);
    chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cpu_addr = SIZE'($urandom_range(DEPTH - 1));
      cpu_data_toRAM = $urandom;
      cpu_wrEn = 1'($urandom_range(1));
      if (i == 3) begin load_start = 1'b1; dump_start = 1'b1; end
      if (i == 7) begin
        halt_req = 1'b1; cpu_wrEn = 1'b1; cpu_addr = SIZE'(101); cpu_data_toRAM = 32'd7;
      end
      #1;
      chk("run_ram_addr", 64'(ram_addr), 64'(cpu_addr));
      chk("run_ram_we", 64'(ram_we), 64'(cpu_wrEn));
      chk("run_ram_din", 64'(ram_data_in), 64'(cpu_data_toRAM));
      chk("run_from_ram", 64'(cpu_data_fromRAM), 64'(ram_data_out));
      step();
      if (cpu_wrEn) ref_mem[cpu_addr % DEPTH] = cpu_data_toRAM;
      load_start = 1'b0; dump_start = 1'b0;
      if (i < 7) chk("run_stays", 64'(state), 64'd2);
    end
    halt_req = 1'b0; cpu_wrEn = 1'b0;
    chk("halt_state", 64'(state), 64'd0);
    chk("halt_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("halt_write", 64'(mem1[101]), 64'd7);

    // overlong load: count saturates at DEPTH while the pointer keeps wrapping
    for (int i = 0; i < 1030; i++) words[i] = $urandom;
    do_load(int'($urandom_range(DEPTH - 1)), 1030, 1'b1);

    // load wrap and auto-run
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    do_load(1022, 4, 1'b0);

    // directed dump with backpressure
    words[0] = 32'h1; words[1] = 32'h3e8;
    do_load(69, 2, 1'b0);
    do_dump(69, 2, 1);

    // full-rate streaming
    do_dump(int'($urandom_range(DEPTH - 1)), 5, 2);

    // randomized load/dump rounds
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(DEPTH - 1));
      for (int i = 0; i < 6; i++) words[i] = $urandom;
      do_load(b, int'($urandom_range(1, 6)), 1'b1);
      do_dump(int'($urandom_range(DEPTH - 1)), int'($urandom_range(1, 7)), 0);
    end

    do_dump(5, 0, 0);

    // simultaneous starts, then run_start ignored during LOAD
    ld_base = SIZE'(10);
    load_start = 1'b1; dump_start = 1'b1; run_start = 1'b1;
    step();
    load_start = 1'b0; dump_start = 1'b0; run_start = 1'b0;
    chk("prio_load", 64'(state), 64'd1);
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("run_in_load_state", 64'(state), 64'd1);
    chk("run_in_load_cpu_rst", 64'(cpu_rst), 64'd1);
    w = $urandom;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = w;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    ref_mem[10] = w;
    chk("prio_load_exit", 64'(state), 64'd0);
    chk("prio_load_count", 64'(load_count), 64'd1);
    chk("prio_load_mem", 64'(mem1[10]), 64'(ref_mem[10]));
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;

    // reset mid-load keeps the partial image
    ld_base = SIZE'(300);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      ld_valid = 1'b1; ld_data = w;
      step();
      ref_mem[300 + i] = w;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_load_state", 64'(state), 64'd0);
    chk("rst_load_ready", 64'(ld_ready), 64'd0);
    ld_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("partial_load_mem0", 64'(mem1[300]), 64'(ref_mem[300]));
    chk("partial_load_mem1", 64'(mem1[301]), 64'(ref_mem[301]));

    // reset mid-run
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("rst_run_pre", 64'(cpu_rst), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_run_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_run_state", 64'(state), 64'd0);
    step();
    rst = 1'b0;

    // reset mid-dump, observed before any clock edge
    dump_base = SIZE'(300); dump_len = (SIZE+1)'(4); dump_ready = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 10 && !dump_valid; i++) step();
    chk("rst_dump_pre_valid", 64'(dump_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_state", 64'(state), 64'd0);
    chk("rst_dump_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_dump_data", 64'(dump_data), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 64'(state), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
